// File: rtl/mesh_term_pkg.sv
// Shared definitions for the terminal-side ingress bank.
//   clog2_min1 : $clog2 that never returns 0, for widths of index signals.
//   slice_lo   : low bit of element idx in a packed bus of w-bit elements.
//   state_t    : output stage state (IDLE = empty, HOLD = out_data valid).
package mesh_term_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mesh_fifo_chan.sv
// Single terminal channel FIFO with occupancy flags and drop accounting.
//   clk, reset     : clock, asynchronous active-low reset
//   push, data_in  : write strobe and packet
//   pop            : head is consumed this edge (only asserted when non-empty)
//   ovf_clr        : clears ovf and drop_cnt (a drop on the same edge wins)
//   data_out       : packet at the head (combinational read)
//   count          : occupancy 0..FIFO_DEPTH
//   full, empty, almost_full : decoded from count
//   ovf, drop_cnt  : sticky drop flag and saturating drop counter
module mesh_fifo_chan
  import mesh_term_pkg::*;
#(
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int CNT_W      = 8,
  localparam int PW        = clog2_min1(FIFO_DEPTH),
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [PCKG_SZ-1:0] data_in,
  input  logic               ovf_clr,
  output logic [PCKG_SZ-1:0] data_out,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               ovf,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               accept;
  logic               drop;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_THRESH));

  // A full channel still accepts when its head leaves on the same edge:
  // the write lands in the slot the pop frees (wr_ptr == rd_ptr when full).
  assign accept = push && (!full || pop);
  assign drop   = push && !accept;

  assign data_out = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; pointers and count
  // define what is valid, and resetting the array would cost a reset tree
  // on every storage bit for no functional gain.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);

      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (drop) begin
        if (ovf_clr)             drop_cnt <= CNT_W'(1);
        else if (~&drop_cnt)     drop_cnt <= drop_cnt + CNT_W'(1);
      end else if (ovf_clr) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mesh_term_fifo_arb.sv
// Terminal ingress bank: NUM_TERM packet FIFOs drained round-robin into one
// registered valid/ready output port.
//   clk, reset                : clock, asynchronous active-low reset
//   push, data_in             : per-channel write strobe / packed packets
//   pndng, almost_full, full  : per-channel occupancy flags
//   ovf, ovf_clr, drop_cnt    : per-channel sticky drop flag, clear, counter
//   out_valid, out_ready      : output handshake
//   out_data, out_src         : output packet and its source channel
module mesh_term_fifo_arb
  import mesh_term_pkg::*;
#(
  parameter int NUM_TERM   = 16,
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int CNT_W      = 8,
  localparam int SRC_W     = clog2_min1(NUM_TERM),
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_TERM-1:0]         push,
  input  logic [NUM_TERM*PCKG_SZ-1:0] data_in,
  output logic [NUM_TERM-1:0]         pndng,
  output logic [NUM_TERM-1:0]         almost_full,
  output logic [NUM_TERM-1:0]         full,
  output logic [NUM_TERM-1:0]         ovf,
  input  logic [NUM_TERM-1:0]         ovf_clr,
  output logic [NUM_TERM*CNT_W-1:0]   drop_cnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PCKG_SZ-1:0]          out_data,
  output logic [SRC_W-1:0]            out_src
);

  logic [PCKG_SZ-1:0] chan_data [NUM_TERM];
  logic [NUM_TERM-1:0] pop;
  logic [SRC_W-1:0]    ptr;
  logic [SRC_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic                load;
  state_t              state_q, state_d;

  for (genvar i = 0; i < NUM_TERM; i++) begin : g_chan
    logic [CW-1:0] count;
    logic          empty;

    mesh_fifo_chan #(
      .PCKG_SZ    (PCKG_SZ),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_THRESH  (AF_THRESH),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .push        (push[i]),
      .pop         (pop[i]),
      .data_in     (data_in[slice_lo(i, PCKG_SZ) +: PCKG_SZ]),
      .ovf_clr     (ovf_clr[i]),
      .data_out    (chan_data[i]),
      .count       (count),
      .full        (full[i]),
      .empty       (empty),
      .almost_full (almost_full[i]),
      .ovf         (ovf[i]),
      .drop_cnt    (drop_cnt[slice_lo(i, CNT_W) +: CNT_W])
    );

    assign pndng[i] = !empty;
  end

  assign out_valid = (state_q == HOLD);
  assign load      = !out_valid || out_ready;

  // Round-robin scan starting just after the last granted channel. Only
  // pre-edge pndng is used, so a push into an empty channel waits a cycle.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_TERM; k++) begin
      if (!gnt_valid && pndng[(int'(ptr) + k) % NUM_TERM]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'((int'(ptr) + k) % NUM_TERM);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && gnt_valid) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (load) state_d = gnt_valid ? HOLD : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output register and pointer only move when a packet is actually taken;
  // an empty scan leaves out_data/out_src/ptr as they were.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= SRC_W'(NUM_TERM - 1);
    end else if (load && gnt_valid) begin
      out_data <= chan_data[gnt_idx];
      out_src  <= gnt_idx;
      ptr      <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mesh_term_fifo_arb.sv
// Directed bench for mesh_term_fifo_arb with default parameters.
module tb_mesh_term_fifo_arb;

  localparam int NUM_TERM = 16;
  localparam int PCKG_SZ  = 40;
  localparam int CNT_W    = 8;
  localparam int SRC_W    = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_TERM-1:0]         push;
  logic [NUM_TERM*PCKG_SZ-1:0] data_in;
  logic [NUM_TERM-1:0]         pndng;
  logic [NUM_TERM-1:0]         almost_full;
  logic [NUM_TERM-1:0]         full;
  logic [NUM_TERM-1:0]         ovf;
  logic [NUM_TERM-1:0]         ovf_clr;
  logic [NUM_TERM*CNT_W-1:0]   drop_cnt;
  logic                        out_valid;
  logic                        out_ready;
  logic [PCKG_SZ-1:0]          out_data;
  logic [SRC_W-1:0]            out_src;

  int n_checks = 0;
  int n_errors = 0;

  mesh_term_fifo_arb dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pndng       (pndng),
    .almost_full (almost_full),
    .full        (full),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .drop_cnt    (drop_cnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int ch, input logic [PCKG_SZ-1:0] d);
    push[ch] = 1'b1;
    data_in[ch*PCKG_SZ +: PCKG_SZ] = d;
  endtask

  function automatic logic [PCKG_SZ-1:0] pk(input int c, input int k);
    return 40'h55_0000_0000 | PCKG_SZ'(c * 256 + k);
  endfunction

  function automatic logic [CNT_W-1:0] dcnt(input int ch);
    return drop_cnt[ch*CNT_W +: CNT_W];
  endfunction

  logic [PCKG_SZ-1:0] exp_d [8];
  int                 exp_s [8];

  initial begin
    reset     = 1'b0;
    push      = '0;
    data_in   = '0;
    ovf_clr   = '0;
    out_ready = 1'b0;

    // Reset state
    #23;
    check("rst_pndng", pndng, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop_cnt, 0);
    @(negedge clk) reset = 1'b1;
    step();

    // Latency and single-channel order on channel 5
    out_ready = 1'b1;
    drive_push(5, 40'hA1);
    step();
    check("lat_pndng5", pndng[5], 1);
    check("lat_valid_e0", out_valid, 0);
    drive_push(5, 40'hA2);
    step();
    check("lat_valid_e1", out_valid, 1);
    check("ord_a1", out_data, 40'hA1);
    check("ord_src", out_src, 5);
    drive_push(5, 40'hA3);
    step();
    push = '0;
    check("ord_a2", out_data, 40'hA2);
    step();
    check("ord_a3", out_data, 40'hA3);
    check("ord_src3", out_src, 5);
    step();
    check("ord_empty_valid", out_valid, 0);
    check("ord_empty_pndng", pndng, 0);

    // Reset asserted mid-stream
    for (int c = 0; c < NUM_TERM; c++) drive_push(c, pk(c, 0));
    step();
    step();
    check("mid_valid_pre", out_valid, 1);
    #2;
    reset = 1'b0;
    push  = '0;
    #1;
    check("mid_pndng", pndng, 0);
    check("mid_valid", out_valid, 0);
    check("mid_full", full, 0);
    check("mid_data", out_data, 0);
    @(negedge clk) reset = 1'b1;
    step();
    check("mid_post1_valid", out_valid, 0);
    step();
    check("mid_post2_valid", out_valid, 0);

    // Round-robin over channels 0, 3, 15
    out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      drive_push(0, pk(0, k));
      drive_push(3, pk(3, k));
      drive_push(15, pk(15, k));
      step();
    end
    push = '0;
    check("rr_0_src", out_src, 0);
    check("rr_0_data", out_data, pk(0, 1));
    out_ready = 1'b1;
    exp_s = '{3, 15, 0, 3, 15, 0, 0, 0};
    exp_d = '{pk(3, 1), pk(15, 1), pk(0, 2), pk(3, 2), pk(15, 2), 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_%0d_src", i + 1), out_src, exp_s[i]);
      check($sformatf("rr_%0d_data", i + 1), out_data, exp_d[i]);
    end
    step();
    check("rr_end_valid", out_valid, 0);

    // Overflow on channel 2 with the output stage stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive_push(2, pk(2, k));
      step();
      check($sformatf("ovf_af_%0d", k), almost_full[2], (k >= 4));
      check($sformatf("ovf_full_%0d", k), full[2], (k >= 5));
    end
    push = '0;
    check("ovf_flag", ovf[2], 1);
    check("ovf_cnt", dcnt(2), 1);
    check("ovf_held", out_data, pk(2, 1));
    ovf_clr[2] = 1'b1;
    step();
    check("clr_flag", ovf[2], 0);
    check("clr_cnt", dcnt(2), 0);
    drive_push(2, pk(2, 90));
    step();
    check("clr_drop_flag", ovf[2], 1);
    check("clr_drop_cnt", dcnt(2), 1);
    ovf_clr = '0;
    for (int i = 0; i < 256; i++) step();
    push = '0;
    check("sat_cnt", dcnt(2), 255);
    check("sat_other", ovf & ~(16'h1 << 2), 0);
    ovf_clr[2] = 1'b1;
    step();
    ovf_clr = '0;
    check("sat_clr_cnt", dcnt(2), 0);

    // Backpressure for 10 cycles while channel 7 fills
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive_push(7, pk(7, i + 1));
      else push = '0;
      step();
      check($sformatf("bp_%0d_data", i), out_data, pk(2, 1));
      check($sformatf("bp_%0d_src", i), out_src, 2);
      check($sformatf("bp_%0d_valid", i), out_valid, 1);
    end
    push = '0;
    check("bp_full7", full[7], 1);
    check("bp_full2", full[2], 1);

    // Full channel 7: push and grant on the same edge
    out_ready = 1'b1;
    drive_push(7, pk(7, 5));
    step();
    push = '0;
    check("fp_src", out_src, 7);
    check("fp_data", out_data, pk(7, 1));
    check("fp_full", full[7], 1);
    check("fp_ovf", ovf[7], 0);
    check("fp_cnt", dcnt(7), 0);
    exp_s = '{2, 7, 2, 7, 2, 7, 2, 7};
    exp_d = '{pk(2, 2), pk(7, 2), pk(2, 3), pk(7, 3), pk(2, 4), pk(7, 4), pk(2, 5), pk(7, 5)};
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("drain_%0d_src", i), out_src, exp_s[i]);
      check($sformatf("drain_%0d_data", i), out_data, exp_d[i]);
    end
    step();
    check("drain_end_valid", out_valid, 0);
    check("drain_end_pndng", pndng, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
